// File: rtl/vram_writer_pkg.sv
// Shared GPU definitions for the VRAM writer: FSM state encoding, default widths,
// and the VRAM address width used when no parameters header has set it.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 14
`endif

package vram_writer_pkg;

    localparam int SRC_ADDR_WIDTH_DEFAULT = 16;
    localparam int LEN_WIDTH_DEFAULT      = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vram_writer_if.sv
// Source-read and VRAM-write buses of the VRAM writer.
// The writer is the master; CPU RAM plus the GPU VRAM port form the slave side.
interface vram_writer_if
    import vram_writer_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH  = SRC_ADDR_WIDTH_DEFAULT,
    parameter int VRAM_ADDR_WIDTH = `VRAM_ADDR_WIDTH
);

    logic                       src_re;
    logic [SRC_ADDR_WIDTH-1:0]  src_addr;
    logic [7:0]                 src_data;
    logic [7:0]                 data;
    logic [VRAM_ADDR_WIDTH-1:0] address;
    logic                       vram_we;

    modport master (
        output src_re, src_addr, data, address, vram_we,
        input  src_data
    );

    modport slave (
        input  src_re, src_addr, data, address, vram_we,
        output src_data
    );

endinterface

// File: rtl/vram_writer.sv
// Copies a block of CPU RAM bytes into VRAM during GPU-writable windows.
// Optional VRAM_WRITER_FILL_EN adds a constant-fill mode (fill / fill_byte inputs).
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 14
`endif

module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH = SRC_ADDR_WIDTH_DEFAULT,
    parameter int LEN_WIDTH      = LEN_WIDTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        writable,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SRC_ADDR_WIDTH-1:0]   src_base,
    input  logic [`VRAM_ADDR_WIDTH-1:0] dst_base,
    input  logic [LEN_WIDTH-1:0]        length,
`ifdef VRAM_WRITER_FILL_EN
    input  logic                        fill,
    input  logic [7:0]                  fill_byte,
`endif
    output logic                        busy,
    output logic                        done,
    vram_writer_if.master               bus
);

    localparam int VAW = `VRAM_ADDR_WIDTH;

    state_t                    state_reg, state_next;
    logic                      accept_reg;
    logic [SRC_ADDR_WIDTH-1:0] src_ptr_reg;
    logic [VAW-1:0]            dst_ptr_reg;
    logic [LEN_WIDTH-1:0]      rd_left_reg;
    logic [LEN_WIDTH-1:0]      wr_left_reg;
    logic                      inflight_reg;
    logic                      hold_valid_reg;
    logic [7:0]                hold_data_reg;
    logic [7:0]                data_reg;
    logic [VAW-1:0]            address_reg;

    logic       start_ok;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] wr_byte;
    logic       fill_mode;
    logic [7:0] fill_data;

    // A start is taken only when fully idle; the accept cycle registers the
    // request so parameters are stable before the FSM leaves IDLE.
    assign start_ok = start && !abort && (state_reg == ST_IDLE) && !accept_reg;

`ifdef VRAM_WRITER_FILL_EN
    logic       fill_reg;
    logic [7:0] fill_byte_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_reg      <= 1'b0;
            fill_byte_reg <= 8'h00;
        end else if (start_ok) begin
            fill_reg      <= fill;
            fill_byte_reg <= fill_byte;
        end
    end

    assign fill_mode = fill_reg;
    assign fill_data = fill_byte_reg;
`else
    assign fill_mode = 1'b0;
    assign fill_data = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wr_byte    = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept_reg) begin
                    state_next = (wr_left_reg == '0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (fill_mode) begin
                    wr_en   = writable && (wr_left_reg != '0);
                    wr_byte = fill_data;
                end else begin
                    // A held byte always drains before a new read is issued,
                    // so hold and in-flight never carry data together.
                    rd_en   = writable && (rd_left_reg != '0) && !hold_valid_reg;
                    wr_en   = writable && (hold_valid_reg || inflight_reg);
                    wr_byte = hold_valid_reg ? hold_data_reg : bus.src_data;
                end
                if (wr_en && (wr_left_reg == LEN_WIDTH'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accept_reg     <= 1'b0;
            src_ptr_reg    <= '0;
            dst_ptr_reg    <= '0;
            rd_left_reg    <= '0;
            wr_left_reg    <= '0;
            inflight_reg   <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= 8'h00;
            data_reg       <= 8'h00;
            address_reg    <= '0;
        end else if (abort) begin
            accept_reg     <= 1'b0;
            inflight_reg   <= 1'b0;
            hold_valid_reg <= 1'b0;
        end else begin
            accept_reg   <= start_ok;
            inflight_reg <= rd_en;
            if (start_ok) begin
                src_ptr_reg <= src_base;
                dst_ptr_reg <= dst_base;
                rd_left_reg <= length;
                wr_left_reg <= length;
            end
            if (rd_en) begin
                src_ptr_reg <= src_ptr_reg + SRC_ADDR_WIDTH'(1);
                rd_left_reg <= rd_left_reg - LEN_WIDTH'(1);
            end
            if (wr_en) begin
                dst_ptr_reg <= dst_ptr_reg + VAW'(1);
                wr_left_reg <= wr_left_reg - LEN_WIDTH'(1);
                data_reg    <= wr_byte;
                address_reg <= dst_ptr_reg;
            end
            if (inflight_reg && !writable) begin
                hold_valid_reg <= 1'b1;
                hold_data_reg  <= bus.src_data;
            end else if (hold_valid_reg && wr_en) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.src_re   = rd_en;
    assign bus.src_addr = src_ptr_reg;
    assign bus.vram_we  = wr_en;
    assign bus.data     = wr_en ? wr_byte : data_reg;
    assign bus.address  = wr_en ? dst_ptr_reg : address_reg;
    assign busy         = accept_reg || (state_reg != ST_IDLE);
    assign done         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_vram_writer.sv
// Scoreboard bench for vram_writer: directed transfers push expected writes,
// a negedge monitor pops and compares every VRAM write.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 14
`endif

module tb_vram_writer;

    localparam int SAW = 16;
    localparam int LW  = 12;
    localparam int VAW = `VRAM_ADDR_WIDTH;

    typedef struct packed {
        logic [VAW-1:0] addr;
        logic [7:0]     data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           writable = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [SAW-1:0] src_base = '0;
    logic [VAW-1:0] dst_base = '0;
    logic [LW-1:0]  length = '0;
    logic           busy;
    logic           done;
    logic [7:0]     src_data_r = 8'h00;
`ifdef VRAM_WRITER_FILL_EN
    logic           fill = 1'b0;
    logic [7:0]     fill_byte = 8'h00;
`endif

    vram_writer_if #(.SRC_ADDR_WIDTH(SAW), .VRAM_ADDR_WIDTH(VAW)) bus ();

    vram_writer #(.SRC_ADDR_WIDTH(SAW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .writable  (writable),
        .start     (start),
        .abort     (abort),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .length    (length),
`ifdef VRAM_WRITER_FILL_EN
        .fill      (fill),
        .fill_byte (fill_byte),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source RAM: byte at address a is a[7:0] ^ 0x3C, one cycle read latency.
    always @(posedge clk) src_data_r <= bus.src_re ? (bus.src_addr[7:0] ^ 8'h3C) : 8'hEE;
    assign bus.src_data = src_data_r;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   we_cyc_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   busy_cnt = 0;
    int   re_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    task automatic expect_wr(input int a, input logic [7:0] d);
        exp_q.push_back(exp_t'{VAW'(a), d});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (bus.src_re) re_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                $display("cycle %0d: done", cyc);
            end
            if (bus.vram_we) begin
                exp_t e;
                we_cyc_q.push_back(cyc);
                $display("cycle %0d: write addr=%h data=%h", cyc, bus.address, bus.data);
                chk("we_needs_writable", 32'(writable), 32'd1);
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.address), 32'(e.addr));
                    chk("wr_data", 32'(bus.data), 32'(e.data));
                end
            end
        end
    end

    task automatic do_start(input logic [SAW-1:0] sb, input logic [VAW-1:0] db,
                            input logic [LW-1:0] ln, output int s);
        @(posedge clk); #1;
        start    = 1'b1;
        src_base = sb;
        dst_base = db;
        length   = ln;
        s        = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit);
        int n;
        n = 0;
        while (done_cnt == base && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt - base), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_src_re"},   32'(bus.src_re),   32'd0);
        chk({tag, "_src_addr"}, 32'(bus.src_addr), 32'd0);
        chk({tag, "_data"},     32'(bus.data),     32'd0);
        chk({tag, "_address"},  32'(bus.address),  32'd0);
        chk({tag, "_vram_we"},  32'(bus.vram_we),  32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_done"},     32'(done),         32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, wq0, dn0, bz0, re0, wr_back, vmax;
        vmax = (1 << VAW) - 1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst      = 1'b0;
        writable = 1'b1;

        // Plain 4-byte copy at full rate.
        wq0 = we_cyc_q.size(); dn0 = done_cnt;
        expect_wr('h040, 8'h3C); expect_wr('h041, 8'h3D);
        expect_wr('h042, 8'h3E); expect_wr('h043, 8'h3F);
        do_start(16'h1000, VAW'('h040), LW'(4), s);
        wait_done(dn0, 40);
        chk("t1_writes", 32'(we_cyc_q.size() - wq0), 32'd4);
        if (we_cyc_q.size() >= wq0 + 4) begin
            chk("t1_consecutive", 32'(we_cyc_q[wq0+3] - we_cyc_q[wq0]), 32'd3);
            chk("t1_done_after_last", 32'(done_cyc), 32'(we_cyc_q[wq0+3] + 1));
        end
        repeat (3) @(posedge clk);

        // Zero-length transfer.
        wq0 = we_cyc_q.size(); dn0 = done_cnt; bz0 = busy_cnt;
        do_start(16'h1234, VAW'('h123), LW'(0), s);
        wait_done(dn0, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("zl_done_cycle", 32'(done_cyc), 32'(s + 2));
        chk("zl_busy_cycles", 32'(busy_cnt - bz0), 32'd2);
        chk("zl_no_writes", 32'(we_cyc_q.size() - wq0), 32'd0);

        // writable drops right after the second read; byte 1 must be held.
        wq0 = we_cyc_q.size(); dn0 = done_cnt; re0 = re_cnt;
        expect_wr('h100, 8'h3C); expect_wr('h101, 8'h3D); expect_wr('h102, 8'h3E);
        expect_wr('h103, 8'h3F); expect_wr('h104, 8'h38);
        do_start(16'h2000, VAW'('h100), LW'(5), s);
        repeat (3) @(posedge clk);
        #1;
        writable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        writable = 1'b1;
        wr_back  = cyc;
        wait_done(dn0, 40);
        chk("t3_writes", 32'(we_cyc_q.size() - wq0), 32'd5);
        chk("t3_reads", 32'(re_cnt - re0), 32'd5);
        if (we_cyc_q.size() >= wq0 + 2)
            chk("t3_held_write_cycle", 32'(we_cyc_q[wq0+1]), 32'(wr_back));
        repeat (3) @(posedge clk);

        // Both pointers wrap; a start during the transfer must be ignored.
        wq0 = we_cyc_q.size(); dn0 = done_cnt;
        expect_wr(vmax - 1, 8'hC2); expect_wr(vmax, 8'hC3);
        expect_wr(0, 8'h3C);        expect_wr(1, 8'h3D);
        do_start(16'hFFFE, VAW'(vmax - 1), LW'(4), s);
        @(posedge clk); #1;
        start = 1'b1; src_base = 16'h0000; dst_base = VAW'('h010); length = LW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(dn0, 40);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_writes", 32'(we_cyc_q.size() - wq0), 32'd4);
        chk("t4_single_done", 32'(done_cnt - dn0), 32'd1);

        // Abort in the cycle of the third of eight writes.
        wq0 = we_cyc_q.size(); dn0 = done_cnt;
        expect_wr('h200, 8'h3C); expect_wr('h201, 8'h3D); expect_wr('h202, 8'h3E);
        do_start(16'h3000, VAW'('h200), LW'(8), s);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy_low", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_writes", 32'(we_cyc_q.size() - wq0), 32'd3);
        chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);

        // Abort beats start in the same cycle.
        wq0 = we_cyc_q.size(); dn0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; src_base = 16'h0100; dst_base = VAW'('h020); length = LW'(2);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_start_writes", 32'(we_cyc_q.size() - wq0), 32'd0);
        chk("abort_start_done", 32'(done_cnt - dn0), 32'd0);

        // Reset in the middle of a transfer.
        wq0 = we_cyc_q.size();
        expect_wr('h300, 8'h3C); expect_wr('h301, 8'h3D);
        do_start(16'h3000, VAW'('h300), LW'(8), s);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("midrst");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_writes", 32'(we_cyc_q.size() - wq0), 32'd2);

`ifdef VRAM_WRITER_FILL_EN
        // Constant fill: no source reads.
        wq0 = we_cyc_q.size(); dn0 = done_cnt; re0 = re_cnt;
        expect_wr('h050, 8'hA5); expect_wr('h051, 8'hA5); expect_wr('h052, 8'hA5);
        fill = 1'b1; fill_byte = 8'hA5;
        do_start(16'h4000, VAW'('h050), LW'(3), s);
        fill = 1'b0;
        wait_done(dn0, 40);
        chk("fill_writes", 32'(we_cyc_q.size() - wq0), 32'd3);
        chk("fill_no_reads", 32'(re_cnt - re0), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
